// File: rtl/hazard_bypass_control_if.sv
// Execute-stage side of the hazard/bypass controller: decode insn, redirect and
// exception inputs, plus the bypass selects and pipeline-latch controls.
interface hazard_bypass_control_if;
  logic [31:0] fd_insn;
  logic        take_branch;
  logic        j_took_branch;
  logic        write_exception;
  logic        mx_bypass_A;
  logic        wx_bypass_A;
  logic        mx_bypass_B;
  logic        wx_bypass_B;
  logic        stall;
  logic        flush;
  logic        md_busy;

  modport master (
    output fd_insn, take_branch, j_took_branch, write_exception,
    input  mx_bypass_A, wx_bypass_A, mx_bypass_B, wx_bypass_B,
    input  stall, flush, md_busy
  );

  modport slave (
    input  fd_insn, take_branch, j_took_branch, write_exception,
    output mx_bypass_A, wx_bypass_A, mx_bypass_B, wx_bypass_B,
    output stall, flush, md_busy
  );
endinterface

// File: rtl/hazard_bypass_control.sv
// Tracks X/M/W destination tags, drives the execute-stage bypass selects and
// the flush / load-use / mul-div stall controls for the F/D/X latches.
module hazard_bypass_control #(
  parameter int unsigned MD_CYCLES = 32
) (
  input logic                    clock,
  input logic                    reset,
  hazard_bypass_control_if.slave bus
);

  typedef enum logic [4:0] {
    OP_RTYPE = 5'b00000,
    OP_J     = 5'b00001,
    OP_BNE   = 5'b00010,
    OP_JAL   = 5'b00011,
    OP_JR    = 5'b00100,
    OP_ADDI  = 5'b00101,
    OP_BLT   = 5'b00110,
    OP_SW    = 5'b00111,
    OP_LW    = 5'b01000,
    OP_SETX  = 5'b10101,
    OP_BEX   = 5'b10110
  } opcode_t;

  typedef enum logic [4:0] {
    ALU_MUL = 5'b00110,
    ALU_DIV = 5'b00111
  } alu_op_t;

  typedef enum logic {
    IDLE,
    BUSY
  } md_state_t;

  typedef struct packed {
    logic       valid;
    logic       writes;
    logic [4:0] dest;
    logic       is_load;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       use_a;
    logic       use_b;
  } stage_t;

  localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 2);

  function automatic stage_t decode(input logic [31:0] insn);
    stage_t r;
    r       = '0;
    r.valid = 1'b1;
    case (insn[31:27])
      OP_RTYPE: begin
        r.use_a  = 1'b1;
        r.src_a  = insn[21:17];
        r.use_b  = 1'b1;
        r.src_b  = insn[16:12];
        r.writes = 1'b1;
        r.dest   = insn[26:22];
      end
      OP_ADDI: begin
        r.use_a  = 1'b1;
        r.src_a  = insn[21:17];
        r.writes = 1'b1;
        r.dest   = insn[26:22];
      end
      OP_LW: begin
        r.use_a   = 1'b1;
        r.src_a   = insn[21:17];
        r.writes  = 1'b1;
        r.dest    = insn[26:22];
        r.is_load = 1'b1;
      end
      OP_SW: begin
        r.use_a = 1'b1;
        r.src_a = insn[21:17];
        r.use_b = 1'b1;
        r.src_b = insn[26:22];
      end
      OP_BNE, OP_BLT: begin
        r.use_a = 1'b1;
        r.src_a = insn[26:22];
        r.use_b = 1'b1;
        r.src_b = insn[21:17];
      end
      OP_JR: begin
        r.use_b = 1'b1;
        r.src_b = insn[26:22];
      end
      OP_BEX: begin
        r.use_a = 1'b1;
        r.src_a = 5'd30;
      end
      OP_JAL: begin
        r.writes = 1'b1;
        r.dest   = 5'd31;
      end
      OP_SETX: begin
        r.writes = 1'b1;
        r.dest   = 5'd30;
      end
      default: ;
    endcase
    // r0 is never a real destination, so it never takes part in forwarding
    if (r.dest == '0) r.writes = 1'b0;
    return r;
  endfunction

  function automatic logic fwd(input stage_t producer, input logic use_src,
                               input logic [4:0] src);
    return use_src & producer.valid & producer.writes &
           (producer.dest == src) & (src != '0);
  endfunction

  stage_t     x_q, m_q, w_q;
  stage_t     x_d, m_d, w_d;
  stage_t     x_exc;
  stage_t     dec;
  md_state_t  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic dec_is_sw;
  logic dec_is_md;
  logic load_use;
  logic redirect;
  logic md_busy;
  logic unused_fields;

  assign dec       = decode(bus.fd_insn);
  assign dec_is_sw = (bus.fd_insn[31:27] == OP_SW);
  assign dec_is_md = (bus.fd_insn[31:27] == OP_RTYPE) &&
                     ((bus.fd_insn[6:2] == ALU_MUL) || (bus.fd_insn[6:2] == ALU_DIV));

  // A store whose data operand is the load result is served later on the WM path
  assign load_use = x_q.valid & x_q.is_load & (x_q.dest != '0) &
                    ((dec.use_a & (dec.src_a == x_q.dest)) |
                     (dec.use_b & (dec.src_b == x_q.dest) & ~dec_is_sw));

  assign redirect = reset & (bus.take_branch | bus.j_took_branch);
  assign md_busy  = (state_q == BUSY);

  assign bus.mx_bypass_A = x_q.valid & fwd(m_q, x_q.use_a, x_q.src_a);
  assign bus.wx_bypass_A = x_q.valid & fwd(w_q, x_q.use_a, x_q.src_a);
  assign bus.mx_bypass_B = x_q.valid & fwd(m_q, x_q.use_b, x_q.src_b);
  assign bus.wx_bypass_B = x_q.valid & fwd(w_q, x_q.use_b, x_q.src_b);
  assign bus.flush       = redirect;
  assign bus.stall       = md_busy | (load_use & ~redirect);
  assign bus.md_busy     = md_busy;

  assign unused_fields = ^{m_q.is_load, m_q.src_a, m_q.src_b, m_q.use_a, m_q.use_b,
                           w_q.is_load, w_q.src_a, w_q.src_b, w_q.use_a, w_q.use_b,
                           bus.fd_insn[11:7], bus.fd_insn[1:0]};

  always_comb begin
    x_exc = x_q;
    if (bus.write_exception) begin
      x_exc.dest   = 5'd30;
      x_exc.writes = 1'b1;
    end

    x_d     = x_q;
    m_d     = m_q;
    w_d     = m_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (state_q == BUSY) begin
      m_d = '0;
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - 6'd1;
    end else if (redirect || load_use) begin
      x_d = '0;
      m_d = x_exc;
    end else begin
      x_d = dec;
      m_d = x_exc;
      // Entry edge counts as the first busy cycle; the final X cycle runs idle
      if (dec_is_md) begin
        state_d = BUSY;
        cnt_d   = MD_LOAD;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      x_q     <= x_d;
      m_q     <= m_d;
      w_q     <= w_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_bypass_control.sv
// Directed bench for hazard_bypass_control: bypass, load-use, flush, mul/div
// occupancy, exception retagging and asynchronous reset.
module tb_hazard_bypass_control;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [6:0] outs;

  hazard_bypass_control_if bus ();

  hazard_bypass_control #(.MD_CYCLES(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // {mx_A, wx_A, mx_B, wx_B, stall, flush, md_busy}
  assign outs = {bus.mx_bypass_A, bus.wx_bypass_A, bus.mx_bypass_B, bus.wx_bypass_B,
                 bus.stall, bus.flush, bus.md_busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [31:0] BEX    = {5'b10110, 27'd0};
  localparam logic [31:0] NOP    = 32'd0;

  function automatic logic [31:0] r_ins(input logic [4:0] alu, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt_f);
    return {5'b00000, rd, rs, rt_f, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt_f);
    return r_ins(ALU_ADD, rd, rs, rt_f);
  endfunction

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic nops(input int n);
    bus.fd_insn         = NOP;
    bus.take_branch     = 1'b0;
    bus.j_took_branch   = 1'b0;
    bus.write_exception = 1'b0;
    repeat (n) adv();
  endtask

  task automatic test_reset();
    reset               = 1'b0;
    bus.fd_insn         = add(5'd1, 5'd2, 5'd3);
    bus.take_branch     = 1'b1;
    bus.j_took_branch   = 1'b1;
    bus.write_exception = 1'b1;
    smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL reset_low got=%b exp=0000000", outs); end
    adv(); adv();
    smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL reset_held got=%b exp=0000000", outs); end
    adv();
    nops(0);
    reset = 1'b1;
    smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL reset_release got=%b exp=0000000", outs); end
    adv();
  endtask

  task automatic test_bypass();
    nops(3);
    bus.fd_insn = add(5'd1, 5'd2, 5'd3); adv();
    bus.fd_insn = add(5'd4, 5'd1, 5'd1); smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL bp_first got=%b exp=0000000", outs); end
    adv();
    bus.fd_insn = add(5'd5, 5'd1, 5'd0); smp();
    total++; if (outs !== 7'b1010000) begin bad++; $display("FAIL bp_mx_ab got=%b exp=1010000", outs); end
    adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b0100000) begin bad++; $display("FAIL bp_wx_a got=%b exp=0100000", outs); end
    adv();
    nops(2);
    bus.fd_insn = add(5'd1, 5'd2, 5'd3); adv();
    bus.fd_insn = add(5'd1, 5'd4, 5'd5); adv();
    bus.fd_insn = add(5'd6, 5'd1, 5'd1); adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b1111000) begin bad++; $display("FAIL bp_mx_wx_both got=%b exp=1111000", outs); end
    adv();
  endtask

  task automatic test_load_use();
    nops(3);
    bus.fd_insn = i_ins(OP_LW, 5'd5, 5'd2); adv();
    bus.fd_insn = add(5'd6, 5'd5, 5'd7); smp();
    total++; if (outs !== 7'b0000100) begin bad++; $display("FAIL lu_stall got=%b exp=0000100", outs); end
    adv();
    smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL lu_one_cycle got=%b exp=0000000", outs); end
    adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b0100000) begin bad++; $display("FAIL lu_wx_after got=%b exp=0100000", outs); end
    adv();
    nops(2);
    bus.fd_insn = i_ins(OP_LW, 5'd5, 5'd2); adv();
    bus.fd_insn = i_ins(OP_SW, 5'd5, 5'd8); smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL lu_sw_data_nostall got=%b exp=0000000", outs); end
    adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b0010000) begin bad++; $display("FAIL lu_sw_mx_b got=%b exp=0010000", outs); end
    adv();
    nops(2);
    bus.fd_insn = i_ins(OP_LW, 5'd5, 5'd2); adv();
    bus.fd_insn = i_ins(OP_SW, 5'd9, 5'd5); smp();
    total++; if (outs !== 7'b0000100) begin bad++; $display("FAIL lu_sw_addr_stall got=%b exp=0000100", outs); end
    adv();
    nops(2);
    bus.fd_insn = i_ins(OP_LW, 5'd0, 5'd2); adv();
    bus.fd_insn = add(5'd6, 5'd0, 5'd0); smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL lu_r0_nostall got=%b exp=0000000", outs); end
    adv();
    nops(2);
  endtask

  task automatic test_flush();
    nops(3);
    bus.fd_insn = i_ins(OP_LW, 5'd5, 5'd2); adv();
    bus.fd_insn = add(5'd6, 5'd5, 5'd7);
    bus.take_branch = 1'b1; smp();
    total++; if (outs !== 7'b0000010) begin bad++; $display("FAIL fl_over_lu got=%b exp=0000010", outs); end
    adv();
    bus.take_branch = 1'b0; smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL fl_x_bubble got=%b exp=0000000", outs); end
    adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b0100000) begin bad++; $display("FAIL fl_refetch_wx got=%b exp=0100000", outs); end
    adv();
    nops(2);
    bus.fd_insn = add(5'd1, 5'd2, 5'd3); adv();
    bus.fd_insn = add(5'd2, 5'd1, 5'd1);
    bus.j_took_branch = 1'b1; smp();
    total++; if (outs !== 7'b0000010) begin bad++; $display("FAIL fl_jump got=%b exp=0000010", outs); end
    adv();
    bus.j_took_branch = 1'b0;
    bus.fd_insn = add(5'd3, 5'd1, 5'd1); smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL fl_bubble_nobp got=%b exp=0000000", outs); end
    adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b0101000) begin bad++; $display("FAIL fl_m_gets_x got=%b exp=0101000", outs); end
    adv();
  endtask

  task automatic test_exception();
    nops(3);
    bus.fd_insn = add(5'd1, 5'd2, 5'd3); adv();
    bus.write_exception = 1'b1;
    bus.fd_insn = BEX; smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL ex_before got=%b exp=0000000", outs); end
    adv();
    bus.write_exception = 1'b0;
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b1000000) begin bad++; $display("FAIL ex_bex_r30 got=%b exp=1000000", outs); end
    adv();
    nops(2);
    bus.fd_insn = add(5'd1, 5'd2, 5'd3); adv();
    bus.write_exception = 1'b1;
    bus.fd_insn = add(5'd7, 5'd1, 5'd0); adv();
    bus.write_exception = 1'b0;
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL ex_r1_replaced got=%b exp=0000000", outs); end
    adv();
    nops(2);
    bus.fd_insn = add(5'd0, 5'd2, 5'd3); adv();
    bus.fd_insn = add(5'd4, 5'd0, 5'd0); adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL r0_no_bypass got=%b exp=0000000", outs); end
    adv();
  endtask

  task automatic test_muldiv();
    nops(3);
    bus.fd_insn = r_ins(ALU_MUL, 5'd3, 5'd1, 5'd2); adv();
    bus.fd_insn = add(5'd4, 5'd3, 5'd0);
    for (int i = 1; i <= 31; i++) begin
      smp();
      total++; if (outs !== 7'b0000101) begin bad++; $display("FAIL md_busy_cycle%0d got=%b exp=0000101", i, outs); end
      adv();
    end
    smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL md_last_cycle got=%b exp=0000000", outs); end
    adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b1000000) begin bad++; $display("FAIL md_result_mx got=%b exp=1000000", outs); end
    adv();
  endtask

  task automatic test_back_to_back();
    nops(2);
    bus.fd_insn = r_ins(ALU_DIV, 5'd3, 5'd1, 5'd2); adv();
    bus.fd_insn = r_ins(ALU_DIV, 5'd4, 5'd3, 5'd3);
    repeat (31) adv();
    smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL b2b_gap got=%b exp=0000000", outs); end
    adv();
    bus.fd_insn = NOP; smp();
    total++; if (outs !== 7'b1010101) begin bad++; $display("FAIL b2b_second_busy got=%b exp=1010101", outs); end
    repeat (32) adv();
  endtask

  task automatic test_reset_mid_div();
    nops(2);
    bus.fd_insn = add(5'd1, 5'd5, 5'd6); adv();
    bus.fd_insn = r_ins(ALU_DIV, 5'd3, 5'd1, 5'd2); adv();
    smp();
    total++; if (outs !== 7'b1000101) begin bad++; $display("FAIL rd_first got=%b exp=1000101", outs); end
    repeat (20) adv();
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL rd_async_drop got=%b exp=0000000", outs); end
    adv();
    reset = 1'b1; smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL rd_after_release got=%b exp=0000000", outs); end
    adv();
    for (int i = 1; i <= 31; i++) begin
      smp();
      total++; if (outs !== 7'b0000101) begin bad++; $display("FAIL rd_full_busy%0d got=%b exp=0000101", i, outs); end
      adv();
    end
    smp();
    total++; if (outs !== 7'b0000000) begin bad++; $display("FAIL rd_full_last got=%b exp=0000000", outs); end
    bus.fd_insn = NOP;
    adv();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bypass();
    test_load_use();
    test_flush();
    test_exception();
    test_muldiv();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
